vector_pack_1x8: RTL and testbench



---
 rtl/rnn_pkg.sv | 16 +
 rtl/pack_buffer.sv | 45 ++++
 rtl/vector_pack_1x8.sv | 125 ++++++++++++
 tb/tb_vector_pack_1x8.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rnn_pkg.sv
// Shared RNN datapath types and constants: element width, vector width, FP32 zero.
package rnn_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = 8;

    localparam logic [DATA_W-1:0] FP32_ZERO = 32'h0000_0000;

    typedef logic [DATA_W-1:0] fp32_vec_t [LANES];

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } pack_state_t;

endpackage

// File: rtl/pack_buffer.sv
// One 8-lane packing buffer: writes elements at a running index, closes on
// the eighth element or on last, and pads the unwritten upper lanes with +0.0.
module pack_buffer
    import rnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output fp32_vec_t         data,
    output logic [3:0]        count,
    output logic              close_now
);

    logic [2:0] idx;

    assign close_now = wr_en && (wr_last || (idx == 3'd7));

    // idx returns to 0 at close, so the buffer is ready to refill once freed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= 3'd0;
            count <= 4'd0;
            for (int i = 0; i < LANES; i++) begin
                data[i] <= FP32_ZERO;
            end
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (3'(i) == idx) begin
                    data[i] <= wr_data;
                end else if (close_now && (3'(i) > idx)) begin
                    data[i] <= FP32_ZERO;
                end
            end
            if (close_now) begin
                idx   <= 3'd0;
                count <= 4'(idx) + 4'd1;
            end else begin
                idx   <= idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/vector_pack_1x8.sv
// Serial-to-parallel FP32 packer feeding the 8-input adder tree.
// PACK_DOUBLE_BUFFER_EN selects ping-pong buffering (fill while presenting).
//
// state | meaning
// ------+-----------------------------------------------------------
// FILL  | no vector presented; elements are written into the buffer
// SEND  | closed vector presented with m_valid=8'hFF until m_ready
module vector_pack_1x8
    import rnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [LANES-1:0]  m_valid,
    output fp32_vec_t         m_data,
    input  logic              m_ready,
    output logic [3:0]        m_count
);

    pack_state_t state_q, state_d;
    logic        s_ready_d;
    logic        accept;

    assign accept = s_valid && s_ready;

`ifdef PACK_DOUBLE_BUFFER_EN
    logic [1:0] full_q, full_d;
    logic       fill_sel_q, fill_sel_d;
    logic       send_sel_q, send_sel_d;
    logic       hs;
    fp32_vec_t  buf_data [2];
    logic [3:0] buf_count [2];
    logic [1:0] buf_close;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        pack_buffer u_buf (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (accept && (fill_sel_q == 1'(b))),
            .wr_data   (s_data),
            .wr_last   (s_last),
            .data      (buf_data[b]),
            .count     (buf_count[b]),
            .close_now (buf_close[b])
        );
    end

    // Buffers alternate strictly, so presentation order follows fill order
    always_comb begin
        hs         = full_q[send_sel_q] && m_ready;
        full_d     = full_q;
        fill_sel_d = fill_sel_q;
        send_sel_d = send_sel_q;
        if (hs) begin
            full_d[send_sel_q] = 1'b0;
            send_sel_d         = ~send_sel_q;
        end
        if (buf_close[fill_sel_q]) begin
            full_d[fill_sel_q] = 1'b1;
            fill_sel_d         = ~fill_sel_q;
        end
        state_d   = full_d[send_sel_d] ? SEND : FILL;
        s_ready_d = ~full_d[fill_sel_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= 2'b00;
            fill_sel_q <= 1'b0;
            send_sel_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            fill_sel_q <= fill_sel_d;
            send_sel_q <= send_sel_d;
        end
    end

    assign m_data  = buf_data[send_sel_q];
    assign m_count = (state_q == SEND) ? buf_count[send_sel_q] : 4'd0;
`else
    fp32_vec_t  buf_data;
    logic [3:0] buf_count;
    logic       buf_close;

    pack_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept),
        .wr_data   (s_data),
        .wr_last   (s_last),
        .data      (buf_data),
        .count     (buf_count),
        .close_now (buf_close)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (buf_close) state_d = SEND;
            SEND: if (m_ready)   state_d = FILL;
            default: state_d = FILL;
        endcase
        s_ready_d = (state_d == FILL);
    end

    assign m_data  = buf_data;
    assign m_count = (state_q == SEND) ? buf_count : 4'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            s_ready <= 1'b0;
        end else begin
            state_q <= state_d;
            s_ready <= s_ready_d;
        end
    end

    assign m_valid = (state_q == SEND) ? {LANES{1'b1}} : {LANES{1'b0}};

endmodule

// File: tb/tb_vector_pack_1x8.sv
// Directed bench for vector_pack_1x8: vector table plus stall, throughput,
// mid-run reset and single-element handshake sequences.
module tb_vector_pack_1x8;
    import rnn_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic [LANES-1:0]  m_valid;
    fp32_vec_t         m_data;
    logic              m_ready;
    logic [3:0]        m_count;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    vector_pack_1x8 dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .m_count (m_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && (m_valid != '0) && m_ready) hs_cnt++;
    end

    typedef struct packed {
        logic [3:0]   n;
        logic         use_last;
        logic [255:0] in_d;
        logic [255:0] exp_d;
        logic [3:0]   exp_cnt;
    } vec_rec_t;

    vec_rec_t tbl [6];

    function automatic logic [255:0] pack_vec(input fp32_vec_t v);
        logic [255:0] r;
        for (int i = 0; i < LANES; i++) r[i*32 +: 32] = v[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge; returns after the accepting edge
    task automatic push(input logic [31:0] d, input logic last);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        t = 0;
        while (!s_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got s_ready=0 for %0d cycles expected 1", t);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] vec_a, vec_b, expv;
        int           base, acc_cnt, edges, sent, vecs, j;
        logic         acc, hs;

        tbl[0].n = 4'd8; tbl[0].use_last = 1'b0; tbl[0].exp_cnt = 4'd8;
        tbl[0].in_d  = {8{32'h3F80_0000}};
        tbl[0].exp_d = {8{32'h3F80_0000}};
        tbl[1].n = 4'd3; tbl[1].use_last = 1'b1; tbl[1].exp_cnt = 4'd3;
        tbl[1].in_d  = {{5{32'hFFFF_FFFF}}, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        tbl[1].exp_d = {160'h0, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        tbl[2].n = 4'd8; tbl[2].use_last = 1'b1; tbl[2].exp_cnt = 4'd8;
        tbl[2].in_d  = {32'h4100_0000, 32'h40E0_0000, 32'h40C0_0000, 32'h40A0_0000,
                        32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        tbl[2].exp_d = tbl[2].in_d;
        tbl[3].n = 4'd1; tbl[3].use_last = 1'b1; tbl[3].exp_cnt = 4'd1;
        tbl[3].in_d  = {{7{32'hFFFF_FFFF}}, 32'hDEAD_BEEF};
        tbl[3].exp_d = {224'h0, 32'hDEAD_BEEF};
        tbl[4].n = 4'd5; tbl[4].use_last = 1'b1; tbl[4].exp_cnt = 4'd5;
        tbl[4].in_d  = {{3{32'hFFFF_FFFF}}, 32'h0000_0001, 32'h8000_0000, 32'h7FC0_0000,
                        32'h7F80_0000, 32'hBF80_0000};
        tbl[4].exp_d = {96'h0, 32'h0000_0001, 32'h8000_0000, 32'h7FC0_0000,
                        32'h7F80_0000, 32'hBF80_0000};
        tbl[5].n = 4'd7; tbl[5].use_last = 1'b1; tbl[5].exp_cnt = 4'd7;
        tbl[5].in_d  = {32'hFFFF_FFFF, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555,
                        32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        tbl[5].exp_d = {32'h0, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555,
                        32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

        // Reset state and s_ready rising one edge after release
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 256'(s_ready), 256'(0));
        check("rst_m_valid", 256'(m_valid), 256'(0));
        check("rst_m_count", 256'(m_count), 256'(0));
        check("rst_m_data", pack_vec(m_data), 256'h0);
        rst = 1'b0;
        #1;
        check("rel_s_ready_low", 256'(s_ready), 256'(0));
        tick();
        check("rel_s_ready_high", 256'(s_ready), 256'(1));
        check("rel_m_valid", 256'(m_valid), 256'(0));

        // Table of groups, m_ready held high
        m_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < int'(tbl[t].n); k++) begin
                push(tbl[t].in_d[k*32 +: 32], tbl[t].use_last && (k == int'(tbl[t].n) - 1));
            end
            check($sformatf("tbl%0d_valid", t), 256'(m_valid), 256'(8'hFF));
            check($sformatf("tbl%0d_count", t), 256'(m_count), 256'(tbl[t].exp_cnt));
            check($sformatf("tbl%0d_data", t), pack_vec(m_data), tbl[t].exp_d);
            tick();
            check($sformatf("tbl%0d_valid_drop", t), 256'(m_valid), 256'(0));
        end

        // Stall with m_ready low for 20 cycles
        m_ready = 1'b0;
        vec_a = {32'hC100_0000, 32'hC0E0_0000, 32'hC0C0_0000, 32'hC0A0_0000,
                 32'hC080_0000, 32'hC040_0000, 32'hC000_0000, 32'hBF80_0000};
        vec_b = {32'h0B0B_0008, 32'h0B0B_0007, 32'h0B0B_0006, 32'h0B0B_0005,
                 32'h0B0B_0004, 32'h0B0B_0003, 32'h0B0B_0002, 32'h0B0B_0001};
        for (int k = 0; k < 8; k++) push(vec_a[k*32 +: 32], 1'b0);
        acc_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            s_valid = (acc_cnt < 8);
            s_data  = vec_b[(acc_cnt % 8)*32 +: 32];
            acc     = s_valid && s_ready;
            tick();
            if (acc) acc_cnt++;
            check($sformatf("stall%0d_valid", c), 256'(m_valid), 256'(8'hFF));
            check($sformatf("stall%0d_data", c), pack_vec(m_data), vec_a);
        end
        s_valid = 1'b0;
        check("stall_count", 256'(m_count), 256'(8));
        check("stall_s_ready", 256'(s_ready), 256'(0));
`ifdef PACK_DOUBLE_BUFFER_EN
        check("stall_accepts", 256'(acc_cnt), 256'(8));
        m_ready = 1'b1;
        tick();
        check("stall_next_valid", 256'(m_valid), 256'(8'hFF));
        check("stall_next_data", pack_vec(m_data), vec_b);
        check("stall_s_ready_back", 256'(s_ready), 256'(1));
        tick();
        check("stall_drain_valid", 256'(m_valid), 256'(0));
`else
        check("stall_accepts", 256'(acc_cnt), 256'(0));
        m_ready = 1'b1;
        tick();
        check("stall_release_valid", 256'(m_valid), 256'(0));
        check("stall_s_ready_back", 256'(s_ready), 256'(1));
`endif

        // 64 continuous elements, m_ready high
        m_ready = 1'b1;
        edges = 0; sent = 0; vecs = 0;
        while (vecs < 8 && edges < 300) begin
            s_valid = (sent < 64);
            s_data  = 32'hA500_0000 + 32'(sent);
            acc     = s_valid && s_ready;
            hs      = (m_valid != '0) && m_ready;
            if (hs) begin
                for (int i = 0; i < 8; i++) expv[i*32 +: 32] = 32'hA500_0000 + 32'(vecs*8 + i);
                check($sformatf("burst_vec%0d_data", vecs), pack_vec(m_data), expv);
                check($sformatf("burst_vec%0d_count", vecs), 256'(m_count), 256'(8));
            end
            tick();
            edges++;
            if (acc) sent++;
            if (hs) vecs++;
        end
        s_valid = 1'b0;
        check("burst_vectors", 256'(vecs), 256'(8));
`ifdef PACK_DOUBLE_BUFFER_EN
        check("burst_cycles", 256'(edges), 256'(65));
`else
        check("burst_cycles", 256'(edges), 256'(72));
`endif

        // Reset after 5 accepted elements
        for (int k = 0; k < 5; k++) push(32'h5555_0000 + 32'(k), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_m_valid", 256'(m_valid), 256'(0));
        check("midrst_s_ready", 256'(s_ready), 256'(0));
        check("midrst_m_count", 256'(m_count), 256'(0));
        check("midrst_m_data", pack_vec(m_data), 256'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) expv[k*32 +: 32] = 32'h6060_0000 + 32'(k);
        for (int k = 0; k < 8; k++) push(expv[k*32 +: 32], 1'b0);
        check("midrst_vec_valid", 256'(m_valid), 256'(8'hFF));
        check("midrst_vec_data", pack_vec(m_data), expv);
        check("midrst_vec_count", 256'(m_count), 256'(8));
        tick();

        // Single element with last, m_ready toggled
        m_ready = 1'b0;
        push(32'h4120_0000, 1'b1);
        base = hs_cnt;
        check("single_valid", 256'(m_valid), 256'(8'hFF));
        check("single_count", 256'(m_count), 256'(1));
        check("single_data", pack_vec(m_data), {224'h0, 32'h4120_0000});
        tick();
        check("single_hold_valid", 256'(m_valid), 256'(8'hFF));
        j = 0;
        for (int c = 0; c < 6; c++) begin
            m_ready = c[0];
            tick();
        end
        m_ready = 1'b0;
        check("single_handshakes", 256'(hs_cnt - base), 256'(1));
        check("single_valid_drop", 256'(m_valid), 256'(0));
        j = j + 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
